contador_m_prog: RTL

- Parametrised successor to the fixed-modulus binary counter.
- Runtime-programmable modulus, up/down direction, synchronous load, and a one-shot (halt-at-terminal) mode with a small FSM.
- Registered wrap pulse; optional wrap (lap) counter.
- Used wherever the datapath needs timers or sequencers whose length is chosen at run time, e.g. game timeouts and LED sequencing.

---
 rtl/contador_m_prog_if.sv | 65 ++++++
 rtl/contador_m_prog.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/contador_m_prog_if.sv
// -----------------------------------------------------------------------------
// contador_m_prog_if
// Groups the control, data and status signals of the programmable counter.
//
// Optional feature macro: CONTADOR_VOLTAS_EN (adds the voltas lap counter and
// its width parameter V).
//
// Signals:
//   zera_s      synchronous clear
//   conta       count enable
//   desce       direction (0 = up, 1 = down)
//   carga       synchronous load strobe
//   dado        load value            [N-1:0]
//   modulo      runtime modulus       [N:0], 0..2^N
//   modo_unico  0 = free-running, 1 = one-shot
//   Q           count value           [N-1:0]
//   fim         terminal-count flag
//   meio        mid-count flag
//   estouro     one-cycle wrap pulse
//   parado      high while halted in one-shot mode
//   voltas      lap count             [V-1:0] (CONTADOR_VOLTAS_EN only)
//
// Modports:
//   master  drives the controls, observes the status (controller side)
//   slave   the counter itself
// -----------------------------------------------------------------------------
interface contador_m_prog_if #(
    parameter int N = 14
`ifdef CONTADOR_VOLTAS_EN
    ,
    parameter int V = 8
`endif
);
    logic         zera_s;
    logic         conta;
    logic         desce;
    logic         carga;
    logic [N-1:0] dado;
    logic [N:0]   modulo;
    logic         modo_unico;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         estouro;
    logic         parado;
`ifdef CONTADOR_VOLTAS_EN
    logic [V-1:0] voltas;
`endif

    modport master (
        output zera_s, conta, desce, carga, dado, modulo, modo_unico,
        input  Q, fim, meio, estouro, parado
`ifdef CONTADOR_VOLTAS_EN
        , input voltas
`endif
    );

    modport slave (
        input  zera_s, conta, desce, carga, dado, modulo, modo_unico,
        output Q, fim, meio, estouro, parado
`ifdef CONTADOR_VOLTAS_EN
        , output voltas
`endif
    );
endinterface

// File: rtl/contador_m_prog.sv
// -----------------------------------------------------------------------------
// contador_m_prog
// Programmable-modulus up/down counter with synchronous load, one-shot
// (halt-at-terminal) mode, registered wrap pulse and optional lap counter.
//
// Optional feature macro: CONTADOR_VOLTAS_EN (lap counter voltas, width V).
//
// Ports:
//   clock      system clock, rising edge
//   zera_as_n  asynchronous reset, active-low
//   bus        contador_m_prog_if.slave (controls, load data, modulus, status)
//
// Effective modulus Me = max(modulo, 1); terminal value is Me-1 counting up
// and 0 counting down. All range compares are done at N+1 bits so that
// Me = 2^N works and a Q left beyond Me-1 by a modulus change is handled.
// -----------------------------------------------------------------------------
module contador_m_prog #(
    parameter int N = 14
`ifdef CONTADOR_VOLTAS_EN
    ,
    parameter int V = 8
`endif
) (
    input  logic                 clock,
    input  logic                 zera_as_n,
    contador_m_prog_if.slave     bus
);

    typedef enum logic [0:0] {
        CONTANDO = 1'b0,
        PARADO   = 1'b1
    } estado_t;

    localparam logic [N:0]   UM_EXT  = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   ZERO_EXT = {(N+1){1'b0}};
    localparam logic [N-1:0] Q_UM    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] Q_ZERO  = {N{1'b0}};

    logic [N-1:0] q_r;
    logic [N-1:0] q_nxt_s;
    logic         estouro_r;
    logic         estouro_nxt_s;
    estado_t      estado_r;
    estado_t      estado_nxt_s;

    logic [N:0]   me_s;
    logic [N:0]   term_s;
    logic [N:0]   q_ext_s;
    logic [N:0]   dado_ext_s;
    logic [N:0]   meio_alvo_s;

`ifdef CONTADOR_VOLTAS_EN
    logic [V-1:0] voltas_r;
    logic [V-1:0] voltas_nxt_s;
`endif

    // Effective modulus, terminal value and widened operands for compares
    always_comb begin
        if (bus.modulo == ZERO_EXT) begin
            me_s = UM_EXT;
        end else begin
            me_s = bus.modulo;
        end
        term_s      = me_s - UM_EXT;
        q_ext_s     = {1'b0, q_r};
        dado_ext_s  = {1'b0, bus.dado};
        meio_alvo_s = (me_s >> 1) - UM_EXT;
    end

    // Next count, wrap pulse and FSM state (priority: zera_s > carga > conta)
    always_comb begin
        q_nxt_s       = q_r;
        estouro_nxt_s = 1'b0;
        estado_nxt_s  = estado_r;
        if (bus.zera_s) begin
            q_nxt_s      = Q_ZERO;
            estado_nxt_s = CONTANDO;
        end else if (bus.carga) begin
            if (dado_ext_s < me_s) begin
                q_nxt_s = bus.dado;
            end else begin
                q_nxt_s = term_s[N-1:0];
            end
            estado_nxt_s = CONTANDO;
        end else if (bus.conta && (estado_r == CONTANDO)) begin
            if (!bus.desce) begin
                // One-shot stops on the terminal instead of wrapping; this
                // also covers Q already at or beyond the terminal.
                if (bus.modo_unico && ((q_ext_s + UM_EXT) >= term_s)) begin
                    q_nxt_s       = term_s[N-1:0];
                    estouro_nxt_s = 1'b1;
                    estado_nxt_s  = PARADO;
                end else if (q_ext_s >= term_s) begin
                    q_nxt_s       = Q_ZERO;
                    estouro_nxt_s = 1'b1;
                end else begin
                    q_nxt_s = q_r + Q_UM;
                end
            end else begin
                // A Q stranded above Me-1 by a modulus change re-enters the
                // range at the top, in either mode.
                if (q_ext_s > term_s) begin
                    q_nxt_s       = term_s[N-1:0];
                    estouro_nxt_s = 1'b1;
                end else if (bus.modo_unico && (q_ext_s <= UM_EXT)) begin
                    q_nxt_s       = Q_ZERO;
                    estouro_nxt_s = 1'b1;
                    estado_nxt_s  = PARADO;
                end else if (q_ext_s == ZERO_EXT) begin
                    q_nxt_s       = term_s[N-1:0];
                    estouro_nxt_s = 1'b1;
                end else begin
                    q_nxt_s = q_r - Q_UM;
                end
            end
        end else begin
            q_nxt_s       = q_r;
            estouro_nxt_s = 1'b0;
            estado_nxt_s  = estado_r;
        end
    end

    // Counter, wrap pulse and FSM state registers
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            q_r       <= Q_ZERO;
            estouro_r <= 1'b0;
            estado_r  <= CONTANDO;
        end else begin
            q_r       <= q_nxt_s;
            estouro_r <= estouro_nxt_s;
            estado_r  <= estado_nxt_s;
        end
    end

`ifdef CONTADOR_VOLTAS_EN
    // Next lap count: advances with every edge that raises estouro
    always_comb begin
        if (bus.zera_s) begin
            voltas_nxt_s = {V{1'b0}};
        end else if (estouro_nxt_s) begin
            voltas_nxt_s = voltas_r + {{(V-1){1'b0}}, 1'b1};
        end else begin
            voltas_nxt_s = voltas_r;
        end
    end

    // Lap counter register
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            voltas_r <= {V{1'b0}};
        end else begin
            voltas_r <= voltas_nxt_s;
        end
    end

    assign bus.voltas = voltas_r;
`endif

    assign bus.Q       = q_r;
    assign bus.estouro = estouro_r;
    assign bus.parado  = (estado_r == PARADO);
    // fim tracks desce combinationally so a direction change shows at once
    assign bus.fim     = bus.desce ? (q_r == Q_ZERO) : (q_ext_s == term_s);
    assign bus.meio    = (me_s >= {{(N-1){1'b0}}, 2'b10}) && (q_ext_s == meio_alvo_s);

endmodule
